// File: rtl/gb_frame_capture.sv
// Captures the Game Boy LCD strobe stream into a double-buffered 2bpp frame store.
// The strobes are level signals sampled in the core clock domain. Each clean frame flips the bank handed to scan-out.
module gb_frame_capture #(
    parameter int H_PIXELS   = 160,
    parameter int V_LINES    = 144,
    parameter int ADDR_WIDTH = 16
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [1:0]            pixel_data,
    input  logic                  pixel_clock,
    input  logic                  pixel_latch,
    input  logic                  hsync,
    input  logic                  vsync,
    output logic                  fb_wr_en,
    output logic [ADDR_WIDTH-1:0] fb_wr_addr,
    output logic [1:0]            fb_wr_data,
    output logic                  fb_rd_bank,
    output logic                  frame_done,
    output logic [7:0]            frame_count,
    output logic                  err_overrun,
    output logic                  err_short
);

    localparam int PIX_W = ADDR_WIDTH - 1;
    localparam int COL_W = $clog2(H_PIXELS + 1);
    localparam int ROW_W = $clog2(V_LINES + 1);

    localparam logic [COL_W-1:0] H_MAX  = COL_W'(H_PIXELS);
    localparam logic [ROW_W-1:0] V_MAX  = ROW_W'(V_LINES);
    localparam logic [PIX_W-1:0] H_STEP = PIX_W'(H_PIXELS);

    // Strobe lanes: 0 pixel_clock, 1 pixel_latch, 2 hsync, 3 vsync
    logic [3:0] strobe_in;
    logic [3:0] s1_reg;
    logic [3:0] s2_reg;
    logic [3:0] strobe_edge;
    logic [1:0] pix_data_s1_reg;

    assign strobe_in = {vsync, hsync, pixel_latch, pixel_clock};

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_edge
            assign strobe_edge[gi] = s1_reg[gi] & ~s2_reg[gi];
        end
    endgenerate

    logic [COL_W-1:0] col_reg,       col_next;
    logic [ROW_W-1:0] row_reg,       row_next;
    logic [PIX_W-1:0] line_base_reg, line_base_next;
    logic             wr_next;
    logic             overrun_set;
    logic             short_set;
    logic             flip;

    // Events resolve in order: pixel write, column/row update, then vsync overrides.
    always_comb begin
        col_next       = col_reg;
        row_next       = row_reg;
        line_base_next = line_base_reg;
        wr_next        = 1'b0;
        overrun_set    = 1'b0;
        short_set      = 1'b0;
        flip           = 1'b0;

        if (strobe_edge[0]) begin
            if (col_reg < H_MAX && row_reg < V_MAX) begin
                wr_next  = 1'b1;
                col_next = col_reg + 1'b1;
            end else begin
                overrun_set = 1'b1;
            end
        end

        if (strobe_edge[1] || strobe_edge[2]) begin
            col_next = '0;
        end

        if (strobe_edge[2]) begin
            if (row_reg < V_MAX) begin
                row_next       = row_reg + 1'b1;
                line_base_next = line_base_reg + H_STEP;
            end else begin
                overrun_set = 1'b1;
            end
        end

        // The frame check sees the row after any same-cycle hsync advance.
        if (strobe_edge[3]) begin
            if (row_next == V_MAX) begin
                flip = 1'b1;
            end else begin
                short_set = 1'b1;
            end
            row_next       = '0;
            col_next       = '0;
            line_base_next = '0;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            s1_reg          <= '0;
            s2_reg          <= '0;
            pix_data_s1_reg <= '0;
            col_reg         <= '0;
            row_reg         <= '0;
            line_base_reg   <= '0;
            fb_wr_en        <= 1'b0;
            fb_wr_addr      <= '0;
            fb_wr_data      <= '0;
            fb_rd_bank      <= 1'b0;
            frame_done      <= 1'b0;
            frame_count     <= '0;
            err_overrun     <= 1'b0;
            err_short       <= 1'b0;
        end else begin
            s1_reg          <= strobe_in;
            s2_reg          <= s1_reg;
            pix_data_s1_reg <= pixel_data;
            col_reg         <= col_next;
            row_reg         <= row_next;
            line_base_reg   <= line_base_next;
            fb_wr_en        <= wr_next;
            frame_done      <= flip;

            // The write bank is always the one scan-out is not reading.
            if (wr_next) begin
                fb_wr_addr <= {~fb_rd_bank, line_base_reg + PIX_W'(col_reg)};
                fb_wr_data <= pix_data_s1_reg;
            end

            if (flip) begin
                fb_rd_bank  <= ~fb_rd_bank;
                frame_count <= frame_count + 8'd1;
            end

            if (overrun_set) begin
                err_overrun <= 1'b1;
            end
            if (short_set) begin
                err_short <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_gb_frame_capture.sv
// Directed bench for gb_frame_capture using a reduced 12x5 frame geometry.
// A negedge monitor logs framebuffer writes and frame_done pulses for the scenario tasks.
module tb_gb_frame_capture;

    localparam int H  = 12;
    localparam int V  = 5;
    localparam int AW = 8;
    localparam int NPIX = H * V;

    logic          clock;
    logic          reset;
    logic [1:0]    pixel_data;
    logic          pixel_clock;
    logic          pixel_latch;
    logic          hsync;
    logic          vsync;
    logic          fb_wr_en;
    logic [AW-1:0] fb_wr_addr;
    logic [1:0]    fb_wr_data;
    logic          fb_rd_bank;
    logic          frame_done;
    logic [7:0]    frame_count;
    logic          err_overrun;
    logic          err_short;

    gb_frame_capture #(
        .H_PIXELS  (H),
        .V_LINES   (V),
        .ADDR_WIDTH(AW)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .pixel_data (pixel_data),
        .pixel_clock(pixel_clock),
        .pixel_latch(pixel_latch),
        .hsync      (hsync),
        .vsync      (vsync),
        .fb_wr_en   (fb_wr_en),
        .fb_wr_addr (fb_wr_addr),
        .fb_wr_data (fb_wr_data),
        .fb_rd_bank (fb_rd_bank),
        .frame_done (frame_done),
        .frame_count(frame_count),
        .err_overrun(err_overrun),
        .err_short  (err_short)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;
    int log_n  = 0;
    int done_n = 0;
    logic [AW-1:0] log_addr [0:255];
    logic [1:0]    log_data [0:255];

    always @(negedge clock) begin
        if (fb_wr_en) begin
            if (log_n < 256) begin
                log_addr[log_n] = fb_wr_addr;
                log_data[log_n] = fb_wr_data;
            end
            log_n++;
        end
        if (frame_done) done_n++;
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        pixel_clock = 1'b0; pixel_latch = 1'b0; hsync = 1'b0; vsync = 1'b0; pixel_data = 2'b00;
        repeat (3) step();
        reset = 1'b0;
        step();
        log_n = 0;
        done_n = 0;
    endtask

    task automatic pulse_pix(input logic [1:0] d);
        pixel_clock = 1'b1; pixel_data = d;
        step();
        pixel_clock = 1'b0;
        step();
    endtask

    task automatic pulse_latch();
        pixel_latch = 1'b1; step(); pixel_latch = 1'b0; step();
    endtask

    task automatic pulse_hsync();
        hsync = 1'b1; step(); hsync = 1'b0; step();
    endtask

    task automatic pulse_vsync();
        vsync = 1'b1; step(); vsync = 1'b0; step();
        repeat (4) step();
    endtask

    task automatic send_line(input int n);
        pulse_latch();
        for (int c = 0; c < n; c++) pulse_pix(2'(c));
        pulse_hsync();
    endtask

    task automatic send_frame();
        for (int r = 0; r < V; r++) send_line(H);
        pulse_vsync();
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if ({fb_wr_en, fb_wr_addr, fb_wr_data, fb_rd_bank, frame_done, frame_count, err_overrun, err_short} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: en=%b addr=%h data=%b bank=%b done=%b cnt=%0d ovr=%b short=%b, want all 0",
                     fb_wr_en, fb_wr_addr, fb_wr_data, fb_rd_bank, frame_done, frame_count, err_overrun, err_short);
        end
        $display("test_reset: done");
    endtask

    task automatic test_latency();
        do_reset();
        pulse_latch();
        pixel_clock = 1'b1; pixel_data = 2'b10;
        step();
        checks++;
        if (fb_wr_en !== 1'b0) begin errors++; $display("FAIL lat_early: en=%b want 0", fb_wr_en); end
        step();
        checks++;
        if (fb_wr_en !== 1'b1 || fb_wr_addr !== 8'h80 || fb_wr_data !== 2'b10) begin
            errors++;
            $display("FAIL lat_write: en=%b addr=%h data=%b want 1/80/10", fb_wr_en, fb_wr_addr, fb_wr_data);
        end
        step();
        checks++;
        if (fb_wr_en !== 1'b0) begin errors++; $display("FAIL lat_one_cycle: en=%b want 0", fb_wr_en); end
        step();
        pixel_clock = 1'b0;
        repeat (4) step();
        checks++;
        if (log_n !== 1) begin errors++; $display("FAIL held_strobe_once: writes=%0d want 1", log_n); end
        $display("test_latency: writes=%0d", log_n);
    endtask

    task automatic test_full_frame();
        int bad;
        do_reset();
        send_frame();
        bad = 0;
        for (int i = 0; i < NPIX; i++)
            if (log_addr[i] !== AW'(8'h80 + i) || log_data[i] !== 2'((i % H) % 4)) bad++;
        checks++;
        if (log_n !== NPIX) begin errors++; $display("FAIL f1_count: writes=%0d want %0d", log_n, NPIX); end
        checks++;
        if (bad != 0) begin errors++; $display("FAIL f1_seq: bad=%0d want 0", bad); end
        checks++;
        if (done_n !== 1 || fb_rd_bank !== 1'b1 || frame_count !== 8'd1) begin
            errors++;
            $display("FAIL f1_status: done=%0d bank=%b cnt=%0d want 1/1/1", done_n, fb_rd_bank, frame_count);
        end
        checks++;
        if (err_overrun !== 1'b0 || err_short !== 1'b0) begin
            errors++; $display("FAIL f1_flags: ovr=%b short=%b want 0/0", err_overrun, err_short);
        end
        $display("test_full_frame: writes=%0d done=%0d bank=%b cnt=%0d", log_n, done_n, fb_rd_bank, frame_count);
    endtask

    task automatic test_second_frame();
        int bad;
        log_n = 0; done_n = 0;
        send_frame();
        bad = 0;
        for (int i = 0; i < NPIX; i++)
            if (log_addr[i] !== AW'(i) || log_data[i] !== 2'((i % H) % 4)) bad++;
        checks++;
        if (log_n !== NPIX || bad != 0) begin
            errors++; $display("FAIL f2_seq: writes=%0d bad=%0d want %0d/0", log_n, bad, NPIX);
        end
        checks++;
        if (done_n !== 1 || fb_rd_bank !== 1'b0 || frame_count !== 8'd2) begin
            errors++;
            $display("FAIL f2_status: done=%0d bank=%b cnt=%0d want 1/0/2", done_n, fb_rd_bank, frame_count);
        end
        $display("test_second_frame: writes=%0d bank=%b cnt=%0d", log_n, fb_rd_bank, frame_count);
    endtask

    task automatic test_overrun();
        int bad;
        do_reset();
        send_line(H + 1);
        for (int r = 1; r < V; r++) send_line(H);
        pulse_vsync();
        bad = 0;
        for (int i = 0; i < NPIX; i++)
            if (log_addr[i] !== AW'(8'h80 + i) || log_data[i] !== 2'((i % H) % 4)) bad++;
        checks++;
        if (log_n !== NPIX || bad != 0) begin
            errors++; $display("FAIL ovr_seq: writes=%0d bad=%0d want %0d/0", log_n, bad, NPIX);
        end
        checks++;
        if (err_overrun !== 1'b1 || err_short !== 1'b0) begin
            errors++; $display("FAIL ovr_flags: ovr=%b short=%b want 1/0", err_overrun, err_short);
        end
        checks++;
        if (done_n !== 1 || fb_rd_bank !== 1'b1 || frame_count !== 8'd1) begin
            errors++;
            $display("FAIL ovr_status: done=%0d bank=%b cnt=%0d want 1/1/1", done_n, fb_rd_bank, frame_count);
        end
        $display("test_overrun: writes=%0d ovr=%b done=%0d", log_n, err_overrun, done_n);
    endtask

    task automatic test_short();
        int bad;
        do_reset();
        for (int r = 0; r < 3; r++) send_line(H);
        pulse_vsync();
        checks++;
        if (err_short !== 1'b1 || done_n !== 0 || fb_rd_bank !== 1'b0 || frame_count !== 8'd0) begin
            errors++;
            $display("FAIL short_status: short=%b done=%0d bank=%b cnt=%0d want 1/0/0/0",
                     err_short, done_n, fb_rd_bank, frame_count);
        end
        log_n = 0; done_n = 0;
        send_frame();
        bad = 0;
        for (int i = 0; i < NPIX; i++)
            if (log_addr[i] !== AW'(8'h80 + i)) bad++;
        checks++;
        if (log_n !== NPIX || bad != 0) begin
            errors++; $display("FAIL short_next_seq: writes=%0d bad=%0d want %0d/0", log_n, bad, NPIX);
        end
        checks++;
        if (done_n !== 1 || fb_rd_bank !== 1'b1 || err_short !== 1'b1 || err_overrun !== 1'b0) begin
            errors++;
            $display("FAIL short_next_status: done=%0d bank=%b short=%b ovr=%b want 1/1/1/0",
                     done_n, fb_rd_bank, err_short, err_overrun);
        end
        $display("test_short: short=%b writes=%0d bank=%b", err_short, log_n, fb_rd_bank);
    endtask

    task automatic test_simultaneous();
        int bad;
        do_reset();
        for (int r = 0; r < V - 1; r++) send_line(H);
        pulse_latch();
        for (int c = 0; c < H - 1; c++) pulse_pix(2'(c));
        pixel_clock = 1'b1; hsync = 1'b1; vsync = 1'b1; pixel_data = 2'b01;
        step();
        pixel_clock = 1'b0; hsync = 1'b0; vsync = 1'b0;
        repeat (5) step();
        bad = 0;
        for (int i = 0; i < NPIX - 1; i++)
            if (log_addr[i] !== AW'(8'h80 + i) || log_data[i] !== 2'((i % H) % 4)) bad++;
        checks++;
        if (log_n !== NPIX || bad != 0) begin
            errors++; $display("FAIL simul_seq: writes=%0d bad=%0d want %0d/0", log_n, bad, NPIX);
        end
        checks++;
        if (log_addr[NPIX-1] !== 8'hBB || log_data[NPIX-1] !== 2'b01) begin
            errors++;
            $display("FAIL simul_last: addr=%h data=%b want bb/01", log_addr[NPIX-1], log_data[NPIX-1]);
        end
        checks++;
        if (done_n !== 1 || fb_rd_bank !== 1'b1 || frame_count !== 8'd1 || err_short !== 1'b0 || err_overrun !== 1'b0) begin
            errors++;
            $display("FAIL simul_status: done=%0d bank=%b cnt=%0d short=%b ovr=%b want 1/1/1/0/0",
                     done_n, fb_rd_bank, frame_count, err_short, err_overrun);
        end
        $display("test_simultaneous: last addr=%h done=%0d", log_addr[NPIX-1], done_n);
    endtask

    task automatic test_reset_midline();
        int bad;
        do_reset();
        send_frame();
        send_line(H);
        send_line(H);
        pulse_latch();
        for (int c = 0; c < 3; c++) pulse_pix(2'(c));
        do_reset();
        checks++;
        if (frame_count !== 8'd0 || fb_rd_bank !== 1'b0 || err_overrun !== 1'b0 || err_short !== 1'b0) begin
            errors++;
            $display("FAIL midrst_state: cnt=%0d bank=%b ovr=%b short=%b want 0/0/0/0",
                     frame_count, fb_rd_bank, err_overrun, err_short);
        end
        send_frame();
        bad = 0;
        for (int i = 0; i < NPIX; i++)
            if (log_addr[i] !== AW'(8'h80 + i) || log_data[i] !== 2'((i % H) % 4)) bad++;
        checks++;
        if (log_n !== NPIX || bad != 0) begin
            errors++; $display("FAIL midrst_seq: writes=%0d bad=%0d want %0d/0", log_n, bad, NPIX);
        end
        checks++;
        if (frame_count !== 8'd1 || fb_rd_bank !== 1'b1 || err_overrun !== 1'b0 || err_short !== 1'b0) begin
            errors++;
            $display("FAIL midrst_status: cnt=%0d bank=%b ovr=%b short=%b want 1/1/0/0",
                     frame_count, fb_rd_bank, err_overrun, err_short);
        end
        $display("test_reset_midline: first addr=%h cnt=%0d", log_addr[0], frame_count);
    endtask

    initial begin
        reset = 1'b1;
        pixel_clock = 1'b0; pixel_latch = 1'b0; hsync = 1'b0; vsync = 1'b0; pixel_data = 2'b00;
        test_reset();
        test_latency();
        test_full_frame();
        test_second_frame();
        test_overrun();
        test_short();
        test_simultaneous();
        test_reset_midline();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
